// File: rtl/bidir_buf_pkg.sv
// bidir_buf_pkg: bridge state encoding (HIZ=00, A_TO_B=01, B_TO_A=10) and turnaround counter width
package bidir_buf_pkg;
  typedef enum logic [1:0] {
    HIZ    = 2'b00,
    A_TO_B = 2'b01,
    B_TO_A = 2'b10
  } state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/tristate_driver.sv
// tristate_driver: drives pad from din while oe is high, otherwise leaves pad high-Z (ports: oe, din, pad)
module tristate_driver #(
  parameter int WIDTH = 1
) (
  input  logic             oe,
  input  logic [WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0] pad
);
  assign pad = oe ? din : {WIDTH{1'bz}};
endmodule

// File: rtl/bidirectional_tristate_buffer.sv
// bidirectional_tristate_buffer: clocked a/b bus bridge with high-Z turnaround (ports: clk, rst, a, b, s, dir, turn, data_q)
module bidirectional_tristate_buffer
  import bidir_buf_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  input  logic             s,
  output logic [1:0]       dir,
  output logic             turn,
  output logic [WIDTH-1:0] data_q
);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= HIZ;
      cnt    <= TURN_LOAD;
      data_q <= '0;
    end else begin
      case (state)
        A_TO_B: begin
          data_q <= a;
          if (s) begin
            state <= HIZ;
            cnt   <= TURN_LOAD;
          end
        end
        B_TO_A: begin
          data_q <= b;
          if (!s) begin
            state <= HIZ;
            cnt   <= TURN_LOAD;
          end
        end
        default:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else state <= s ? B_TO_A : A_TO_B;
      endcase
    end
  assign dir  = state;
  assign turn = state == HIZ;
  tristate_driver #(.WIDTH(WIDTH)) u_drv_a (.oe(state == B_TO_A), .din(b), .pad(a));
  tristate_driver #(.WIDTH(WIDTH)) u_drv_b (.oe(state == A_TO_B), .din(a), .pad(b));
endmodule

// File: tb/tb_bidirectional_tristate_buffer.sv
// tb_bidirectional_tristate_buffer: directed checks of reset, forwarding, turnaround, sweep and async abort
module tb_bidirectional_tristate_buffer;
  logic clk = 0, rst = 1;
  logic s = 0, a_oe = 1, b_oe = 0, a_drv = 0, b_drv = 0;
  logic s3 = 0, a3_oe = 1, b3_oe = 0, a3_drv = 0, b3_drv = 0;
  wire a, b, a3, b3;
  logic [1:0] dir, dir3;
  logic turn, turn3, data_q, data_q3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign a  = a_oe  ? a_drv  : 1'bz;
  assign b  = b_oe  ? b_drv  : 1'bz;
  assign a3 = a3_oe ? a3_drv : 1'bz;
  assign b3 = b3_oe ? b3_drv : 1'bz;
  pulldown (a);
  pulldown (b);
  pulldown (a3);
  pulldown (b3);
  bidirectional_tristate_buffer #(.WIDTH(1), .TURN_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .s(s), .dir(dir), .turn(turn), .data_q(data_q)
  );
  bidirectional_tristate_buffer #(.WIDTH(1), .TURN_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .a(a3), .b(b3), .s(s3), .dir(dir3), .turn(turn3), .data_q(data_q3)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    a_drv = 1; a3_drv = 1;
    #1;
    check("rst_b_z", b, 0);
    check("rst_b3_z", b3, 0);
    check("rst_dir", dir, 0);
    check("rst_turn", turn, 1);
    check("rst_dq", data_q, 0);
    check("rst_dir3", dir3, 0);
    s = 1; a_oe = 0; b_oe = 1; b_drv = 1;
    s3 = 1; a3_oe = 0; b3_oe = 1; b3_drv = 1;
    #1;
    check("rst_a_z", a, 0);
    check("rst_a3_z", a3, 0);
    s = 0; a_oe = 1; b_oe = 0; a_drv = 0; b_drv = 0;
    s3 = 0; a3_oe = 1; b3_oe = 0; a3_drv = 0; b3_drv = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 0;
    tick;
    check("rel_dir", dir, 1);
    check("rel_dir3_e1", dir3, 0);
    tick;
    check("rel_dir3_e2", dir3, 0);
    tick;
    check("rel_dir3_e3", dir3, 1);
    a_drv = 1; a3_drv = 1;
    #1;
    check("ab_b1", b, 1);
    check("ab_b3_1", b3, 1);
    check("ab_dq_lag", data_q, 0);
    tick;
    check("ab_dq1", data_q, 1);
    check("ab_dq3_1", data_q3, 1);
    a_drv = 0;
    #1;
    check("ab_b0", b, 0);
    check("ab_dq_hold", data_q, 1);
    tick;
    check("ab_dq0", data_q, 0);
    s = 1; s3 = 1;
    tick;
    check("ta_dir_hiz", dir, 0);
    check("ta_turn", turn, 1);
    check("ta_dir3_k", dir3, 0);
    a_oe = 0; b_oe = 1; b_drv = 1;
    a3_oe = 0; b3_oe = 1; b3_drv = 1;
    #1;
    check("ta_a_z", a, 0);
    check("ta_a3_z_k", a3, 0);
    check("ta_b", b, 1);
    tick;
    check("ta_dir_ba", dir, 2);
    check("ta_a_fwd", a, 1);
    check("ta_dq_hold", data_q, 0);
    check("ta_dir3_k1", dir3, 0);
    check("ta_a3_z_k1", a3, 0);
    tick;
    check("ta_dq_b", data_q, 1);
    check("ta_dir3_k2", dir3, 0);
    check("ta_a3_z_k2", a3, 0);
    tick;
    check("ta_dir3_k3", dir3, 2);
    check("ta_a3_fwd", a3, 1);
    s3 = 0;
    tick;
    check("tg_dir3_m", dir3, 0);
    check("tg_turn3", turn3, 1);
    s3 = 1;
    tick;
    check("tg_dir3_m1", dir3, 0);
    s3 = 0;
    tick;
    check("tg_dir3_m2", dir3, 0);
    b3_oe = 0; a3_oe = 1; a3_drv = 1;
    tick;
    check("tg_dir3_m3", dir3, 1);
    check("tg_b3_fwd", b3, 1);
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      s = vv[0]; a_oe = ~vv[0]; b_oe = vv[0]; a_drv = vv[2]; b_drv = vv[1];
      for (int c = 1; c <= 10; c++) begin
        tick;
        if (c == 1) check("sw_dir_hiz", dir, 0);
        else begin
          check("sw_dir", dir, vv[0] ? 2 : 1);
          check("sw_fwd", vv[0] ? a : b, vv[0] ? vv[1] : vv[2]);
          check("sw_src", vv[0] ? b : a, vv[0] ? vv[1] : vv[2]);
          if (c >= 3) check("sw_dq", data_q, vv[0] ? vv[1] : vv[2]);
        end
      end
    end
    #3;
    check("mr_a_pre", a, 1);
    rst = 1;
    #1;
    check("mr_a_z", a, 0);
    check("mr_dir", dir, 0);
    check("mr_turn", turn, 1);
    check("mr_dq", data_q, 0);
    #2 rst = 0;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
